uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Frame-level controller for the UART receiver. It detects the start bit and generates the edge/bit timing that drives the majority-vote data sampler (`dat_sam_en`, `edge_count`). It consumes the sampler's voted bit and deserializes an 8-bit frame with optional parity. It reports `P_DATA`/`data_valid` and the parity and stop errors to the receiver top level.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame, sent LSB first.
- `CLK`  in  1  oversampling clock (prescale × baud).
- `RST`  in  1  reset; asynchronous, active-low.
- `RX_IN`  in  1  serial line, idle high (synchronized upstream).
- `PAR_EN`  in  1  1 = parity bit present.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `prescale`  in  6  oversampling ratio; legal values are 8, 16 and 32.
- `sampled_bit`  in  1  voted bit from the sampler; valid when `sampling_done` = 1.
- `sampling_done`  in  1  one-cycle pulse from the sampler, at edge_count = prescale/2 + 1.
- `dat_sam_en`  out  1  sampler enable.
- `edge_count`  out  6  edge position within the current bit, range 0..prescale−1.
- `P_DATA`  out  DATA_WIDTH  last good frame payload.
- `data_valid`  out  1  one-cycle pulse when a good frame completes.
- `par_err`  out  1  parity mismatch in the current or last frame.
- `stp_err`  out  1  stop bit sampled low in the current or last frame.

## Operation
- **Reset values:** state = IDLE. `dat_sam_en`, `edge_count`, bit_count, shift register, `P_DATA`, `data_valid`, `par_err` and `stp_err` are all 0.
- **States:** IDLE, START, DATA, PARITY, STOP. The state register is the `uart_rx_pkg::rx_state_e` enum.
- **IDLE**
  - `dat_sam_en` = 0 and the counters are held at 0.
  - When RX_IN = 0 at a clock edge:
    - next state is START;
    - `edge_count` loads 1, so the detect cycle counts as edge 0;
    - `par_err` and `stp_err` clear;
    - PAR_EN and PAR_TYP are latched internally for the whole frame.
- **All non-IDLE states**
  - `dat_sam_en` = 1.
  - `edge_count` increments each cycle and wraps from prescale−1 to 0.
  - Each wrap ends one bit period and increments bit_count (3 bits, DATA only).
- **START**
  - If `sampling_done` arrives with `sampled_bit` = 1, the start is a glitch. Next state is IDLE, counters clear, no flags change.
  - Otherwise, at the wrap, go to DATA with bit_count = 0.
- **DATA**
  - On `sampling_done`, the shift register takes `sampled_bit` into bit position bit_count (LSB first).
  - At the wrap with bit_count = 7: go to PARITY if the latched PAR_EN = 1, otherwise go to STOP.
- **PARITY**
  - On `sampling_done`, set `par_err` if `sampled_bit` ≠ (^shift_reg ^ latched PAR_TYP).
  - At the wrap, go to STOP.
- **STOP**
  - On `sampling_done`, set `stp_err` if `sampled_bit` = 0.
  - At the wrap, go to IDLE.
  - At that wrap, if neither `par_err` nor `stp_err` is set, including a stop error registered in this same bit: `P_DATA` ← shift register and `data_valid` = 1 for one cycle.
- **Error frames:** `data_valid` is not asserted and `P_DATA` holds its previous value. The error flags stay set until the next start detect.
- **Configuration stability:** `prescale` must be static outside IDLE, since it is shared with the sampler. PAR_EN and PAR_TYP changes mid-frame have no effect because they are latched.
- **Reset mid-frame:** all state clears immediately (asynchronous reset). No `data_valid` is produced for the partial frame.
- **Width rule:** compare `edge_count` against prescale − 6'd1 at 6 bits. No truncation occurs for legal values.

## Timing
- **Frame length:** N = 10 bits without parity, 11 with parity. The frame occupies N×prescale cycles, starting at the detect edge.
- **data_valid:** asserted in the cycle beginning N×prescale edges after the detect edge, coincident with the state being IDLE.
- **Back-to-back frames:** a start bit low in the first IDLE cycle is detected at the next edge. No dead cycles are required between frames.
- **Sampler handshake:** `sampling_done` outside non-IDLE states is ignored. At most one is consumed per bit period.
- **Latency:** `par_err` and `stp_err` are visible one cycle after the `sampling_done` that caused them.
- **Glitch rejection:** with prescale = 8, a rejected start returns to IDLE 6 cycles after the detect edge.

## Structure
- **Package `uart_rx_pkg`:** holds the `rx_state_e` enum, the legal prescale constants (PRESC_8, PRESC_16, PRESC_32) and `DATA_WIDTH_DEF` = 8.
- **Sub-module `edge_bit_counter`:** holds `edge_count` and bit_count.
  - Inputs: enable, clear, prescale.
  - Outputs: edge_count, bit_count, a registered-free `bit_end` = (edge_count == prescale−1).
- **Top level:** `uart_rx_ctrl` holds the FSM, the shift register, the error flags and the output register.

## Test plan
- **Clean frame:** prescale = 8, PAR_EN = 0, byte 0xA5 sent with a stop bit. Expect `data_valid` pulsed once at 80 cycles after the detect edge, `P_DATA` = 0xA5, and both error flags 0.
- **Even parity:** prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity 0. Expect `data_valid` at 176 cycles and `P_DATA` = 0x3C. Repeat with parity 1: expect `par_err` = 1, no `data_valid`, and `P_DATA` still 0x3C.
- **Stop error:** prescale = 32, byte 0xFF with the stop bit low. Expect `stp_err` = 1, no `data_valid`, and the flag cleared at the next start detect.
- **Start glitch:** RX_IN low for 3 cycles at prescale = 8. Expect a return to IDLE, `edge_count` = 0, no flags and no `data_valid`.
- **Back-to-back:** frames 0x01 and 0x80 with zero idle gap at prescale = 8. Expect two `data_valid` pulses exactly 80 cycles apart, with `P_DATA` = 0x01 then 0x80.
- **Reset mid-frame:** RST low during DATA bit 4. Expect all outputs 0 and IDLE. A following frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Oversampling ratios supported by both the controller and the sampler.
    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/edge_bit_counter.sv
// Edge position within the current bit and bit index within the data field.
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       clear,
    input  logic       bit_en,
    input  logic [5:0] prescale,
    output logic [5:0] edge_count,
    output logic [2:0] bit_count,
    output logic       bit_end
);

    logic [5:0] edge_q, edge_d;
    logic [2:0] bit_q, bit_d;

    assign bit_end    = (edge_q == (prescale - 6'd1));
    assign edge_count = edge_q;
    assign bit_count  = bit_q;

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clear) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (enable) begin
            if (bit_end) begin
                edge_d = '0;
                if (bit_en) begin
                    bit_d = bit_q + 3'd1;
                end
            end else begin
                edge_d = edge_q + 6'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit timing for the sampler,
// deserialisation, parity/stop checking and the output data register.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    input  logic                  sampled_bit,
    input  logic                  sampling_done,
    output logic                  dat_sam_en,
    output logic [5:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  taken_q, taken_d;

    logic       cnt_en;
    logic       cnt_clr;
    logic       bit_end;
    logic       sam_ok;
    logic [2:0] bit_count;

    edge_bit_counter u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .enable     (cnt_en),
        .clear      (cnt_clr),
        .bit_en     (state_q == DATA),
        .prescale   (prescale),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .bit_end    (bit_end)
    );

    // Only the first sampler result within a bit period is acted upon.
    assign sam_ok = sampling_done && !taken_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        par_err_d = par_err_q;
        stp_err_d = stp_err_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    cnt_en    = 1'b1;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                cnt_en = 1'b1;
                if (sam_ok && sampled_bit) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                if (sam_ok) begin
                    shift_d[bit_count] = sampled_bit;
                end
                if (bit_end && (bit_count == LAST_BIT)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_en = 1'b1;
                if (sam_ok && (sampled_bit != (^shift_q ^ par_typ_q))) begin
                    par_err_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_en = 1'b1;
                if (sam_ok && !sampled_bit) begin
                    stp_err_d = 1'b1;
                end
                // A stop error seen in this very bit still blocks the frame.
                if (bit_end) begin
                    state_d = IDLE;
                    if (!par_err_d && !stp_err_d) begin
                        pdata_d = shift_q;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        taken_d = taken_q;
        if ((state_d == IDLE) || bit_end) begin
            taken_d = 1'b0;
        end else if (sampling_done) begin
            taken_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            par_err_q <= par_err_d;
            stp_err_q <= stp_err_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            taken_q   <= taken_d;
        end
    end

    assign dat_sam_en = (state_q != IDLE);
    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a simple mid-bit sampler model.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       sampled_bit;
    logic       sampling_done;
    logic       dat_sam_en;
    logic [5:0] edge_count;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         dv_cyc[$];
    logic [7:0] dv_dat[$];

    uart_rx_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .prescale      (prescale),
        .sampled_bit   (sampled_bit),
        .sampling_done (sampling_done),
        .dat_sam_en    (dat_sam_en),
        .edge_count    (edge_count),
        .P_DATA        (P_DATA),
        .data_valid    (data_valid),
        .par_err       (par_err),
        .stp_err       (stp_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Sampler stand-in: one result per bit at edge prescale/2+1.
    assign sampling_done = dat_sam_en && (edge_count == ((prescale >> 1) + 6'd1));
    assign sampled_bit   = RX_IN;

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cyc.push_back(cyc);
            dv_dat.push_back(P_DATA);
            $display("frame: data_valid at cycle %0d P_DATA=%h", cyc, P_DATA);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (prescale) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) sync();
        n_cmp++; if (dat_sam_en !== 1'b0) begin n_err++; $display("FAIL rst_sam_en: got %b expected 0", dat_sam_en); end
        n_cmp++; if (edge_count !== 6'd0) begin n_err++; $display("FAIL rst_edge: got %0d expected 0", edge_count); end
        n_cmp++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL rst_pdata: got %h expected 00", P_DATA); end
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_dv: got %b expected 0", data_valid); end
        n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL rst_par: got %b expected 0", par_err); end
        n_cmp++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL rst_stp: got %b expected 0", stp_err); end
        RST = 1'b1;
        sync();
        $display("test_reset done");
    endtask

    task automatic test_clean();
        int n0 = dv_cyc.size();
        prescale = 6'd8; PAR_EN = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge CLK);
        #1;
        n_cmp++;
        if (dv_cyc.size() != n0 + 1) begin
            n_err++; $display("FAIL clean_dv_count: got %0d pulses expected 1", dv_cyc.size() - n0);
        end else begin
            n_cmp++; if (dv_cyc[n0] - start_cyc != 80) begin n_err++; $display("FAIL clean_latency: got %0d expected 80", dv_cyc[n0] - start_cyc); end
            n_cmp++; if (dv_dat[n0] !== 8'hA5) begin n_err++; $display("FAIL clean_pdata: got %h expected a5", dv_dat[n0]); end
        end
        n_cmp++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin n_err++; $display("FAIL clean_flags: got par=%b stp=%b expected 0 0", par_err, stp_err); end
        sync();
        $display("test_clean done");
    endtask

    task automatic test_parity();
        int n0 = dv_cyc.size();
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        n_cmp++;
        if (dv_cyc.size() != n0 + 1) begin
            n_err++; $display("FAIL par_ok_dv_count: got %0d pulses expected 1", dv_cyc.size() - n0);
        end else begin
            n_cmp++; if (dv_cyc[n0] - start_cyc != 176) begin n_err++; $display("FAIL par_ok_latency: got %0d expected 176", dv_cyc[n0] - start_cyc); end
            n_cmp++; if (dv_dat[n0] !== 8'h3C) begin n_err++; $display("FAIL par_ok_pdata: got %h expected 3c", dv_dat[n0]); end
        end
        n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL par_ok_flag: got %b expected 0", par_err); end
        sync();
        n0 = dv_cyc.size();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (3) sync();
        n_cmp++; if (par_err !== 1'b1) begin n_err++; $display("FAIL par_bad_flag: got %b expected 1", par_err); end
        n_cmp++; if (dv_cyc.size() != n0) begin n_err++; $display("FAIL par_bad_dv: got %0d pulses expected 0", dv_cyc.size() - n0); end
        n_cmp++; if (P_DATA !== 8'h3C) begin n_err++; $display("FAIL par_bad_pdata: got %h expected 3c", P_DATA); end
        $display("test_parity done");
    endtask

    task automatic test_stop_err();
        int n0 = dv_cyc.size();
        prescale = 6'd32; PAR_EN = 1'b0;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        repeat (3) sync();
        n_cmp++; if (stp_err !== 1'b1) begin n_err++; $display("FAIL stop_flag: got %b expected 1", stp_err); end
        n_cmp++; if (par_err !== 1'b0) begin n_err++; $display("FAIL stop_par_cleared: got %b expected 0", par_err); end
        n_cmp++; if (dv_cyc.size() != n0) begin n_err++; $display("FAIL stop_dv: got %0d pulses expected 0", dv_cyc.size() - n0); end
        n_cmp++; if (P_DATA !== 8'h3C) begin n_err++; $display("FAIL stop_pdata: got %h expected 3c", P_DATA); end
        fork
            send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
            begin
                @(posedge CLK);
                #2;
                n_cmp++; if (stp_err !== 1'b0) begin n_err++; $display("FAIL stop_clear_at_detect: got %b expected 0", stp_err); end
                n_cmp++; if (dat_sam_en !== 1'b1) begin n_err++; $display("FAIL stop_detect_sam_en: got %b expected 1", dat_sam_en); end
            end
        join
        @(negedge CLK);
        #1;
        n_cmp++;
        if (dv_cyc.size() != n0 + 1) begin
            n_err++; $display("FAIL stop_next_dv: got %0d pulses expected 1", dv_cyc.size() - n0);
        end else begin
            n_cmp++; if (dv_cyc[n0] - start_cyc != 320) begin n_err++; $display("FAIL stop_next_latency: got %0d expected 320", dv_cyc[n0] - start_cyc); end
            n_cmp++; if (dv_dat[n0] !== 8'h5A) begin n_err++; $display("FAIL stop_next_pdata: got %h expected 5a", dv_dat[n0]); end
        end
        sync();
        $display("test_stop_err done");
    endtask

    task automatic test_glitch();
        int n0 = dv_cyc.size();
        prescale = 6'd8;
        RX_IN = 1'b0;
        sync();
        n_cmp++; if (dat_sam_en !== 1'b1 || edge_count !== 6'd1) begin n_err++; $display("FAIL glitch_detect: got en=%b edge=%0d expected 1 1", dat_sam_en, edge_count); end
        repeat (2) sync();
        RX_IN = 1'b1;
        repeat (2) sync();
        n_cmp++; if (dat_sam_en !== 1'b1 || edge_count !== 6'd5) begin n_err++; $display("FAIL glitch_mid: got en=%b edge=%0d expected 1 5", dat_sam_en, edge_count); end
        sync();
        n_cmp++; if (dat_sam_en !== 1'b0 || edge_count !== 6'd0) begin n_err++; $display("FAIL glitch_return: got en=%b edge=%0d expected 0 0", dat_sam_en, edge_count); end
        n_cmp++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin n_err++; $display("FAIL glitch_flags: got par=%b stp=%b expected 0 0", par_err, stp_err); end
        repeat (20) sync();
        n_cmp++; if (dat_sam_en !== 1'b0) begin n_err++; $display("FAIL glitch_stays_idle: got %b expected 0", dat_sam_en); end
        n_cmp++; if (dv_cyc.size() != n0) begin n_err++; $display("FAIL glitch_dv: got %0d pulses expected 0", dv_cyc.size() - n0); end
        $display("test_glitch done");
    endtask

    task automatic test_back_to_back();
        int n0 = dv_cyc.size();
        int s1;
        prescale = 6'd8; PAR_EN = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        s1 = start_cyc;
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        n_cmp++;
        if (dv_cyc.size() != n0 + 2) begin
            n_err++; $display("FAIL b2b_dv_count: got %0d pulses expected 2", dv_cyc.size() - n0);
        end else begin
            n_cmp++; if (dv_cyc[n0] - s1 != 80) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 80", dv_cyc[n0] - s1); end
            n_cmp++; if (dv_cyc[n0+1] - dv_cyc[n0] != 80) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 80", dv_cyc[n0+1] - dv_cyc[n0]); end
            n_cmp++; if (dv_dat[n0] !== 8'h01) begin n_err++; $display("FAIL b2b_first_data: got %h expected 01", dv_dat[n0]); end
            n_cmp++; if (dv_dat[n0+1] !== 8'h80) begin n_err++; $display("FAIL b2b_second_data: got %h expected 80", dv_dat[n0+1]); end
        end
        sync();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'hC3;
        int n0 = dv_cyc.size();
        prescale = 6'd8; PAR_EN = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        RX_IN = d[4];
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        n_cmp++; if (dat_sam_en !== 1'b0 || edge_count !== 6'd0) begin n_err++; $display("FAIL mid_rst_cnt: got en=%b edge=%0d expected 0 0", dat_sam_en, edge_count); end
        n_cmp++; if (P_DATA !== 8'h00 || data_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out: got pdata=%h dv=%b expected 00 0", P_DATA, data_valid); end
        n_cmp++; if (par_err !== 1'b0 || stp_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: got par=%b stp=%b expected 0 0", par_err, stp_err); end
        RX_IN = 1'b1;
        sync();
        RST = 1'b1;
        sync();
        n0 = dv_cyc.size();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        n_cmp++;
        if (dv_cyc.size() != n0 + 1) begin
            n_err++; $display("FAIL mid_rst_next_dv: got %0d pulses expected 1", dv_cyc.size() - n0);
        end else begin
            n_cmp++; if (dv_dat[n0] !== 8'h55) begin n_err++; $display("FAIL mid_rst_next_data: got %h expected 55", dv_dat[n0]); end
            n_cmp++; if (dv_cyc[n0] - start_cyc != 80) begin n_err++; $display("FAIL mid_rst_next_latency: got %0d expected 80", dv_cyc[n0] - start_cyc); end
        end
        sync();
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_parity();
        test_stop_err();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
